// File: rtl/spike_out_buffer.sv
// spike_out_buffer: scans a neuron_core spike vector one neuron per cycle and queues timestamped events in a Wishbone-drained FIFO.
// Latency: vector bit i tested in cycle i+1 after acceptance, event readable from cycle i+2; Wishbone ack one cycle after a matched request.
// Backpressure: spike_ready_o low while scanning; pushes into a full FIFO are dropped and set OVF. Optional SPIKE_OUT_IRQ_EN adds irq_o.
module spike_out_buffer #(
  parameter int          NUM_NEURONS = 32,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_valid_i,
  input  logic [NUM_NEURONS-1:0] spike_vec_i,
  output logic                   spike_ready_o,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o
`ifdef SPIKE_OUT_IRQ_EN
  ,
  output logic                   irq_o
`endif
);

  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_TICK   = 2'd3;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                 state_q, state_nxt;
  logic [NUM_NEURONS-1:0] vec_q;
  logic [IW-1:0]          idx_q;
  logic [15:0]            tick_q;
  logic                   ovf_q;

  logic                   accept;
  logic                   scan_busy;
  logic                   scan_done;
  logic                   push_req;

  logic [31:0]            mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   empty, full;
  logic                   do_push, ovf_evt;

  logic                   addr_hit, wb_req;
  logic [1:0]             offset;
  logic                   pop, ctrl_wr, flush, tick_clr;
  logic [31:0]            rd_mux;
  logic [31:0]            status_word;
  logic                   unused_bits;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (spike_valid_i) state_nxt = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spike_ready_o = (state_q == IDLE);
    scan_busy     = (state_q == SCAN);
    accept        = (state_q == IDLE) && spike_valid_i;
    push_req      = (state_q == SCAN) && vec_q[idx_q];
    scan_done     = (state_q == SCAN) && (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      vec_q <= spike_vec_i;
      idx_q <= '0;
    end else if (scan_busy && !scan_done) begin
      idx_q <= idx_q + IW'(1);
    end
  end

  // ---------------- Wishbone decode ----------------
  assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign offset   = wbs_adr_i[3:2];
  // Gating on the current ack keeps acks from ever landing on consecutive cycles.
  assign wb_req   = wbs_cyc_i && wbs_stb_i && addr_hit && !wbs_ack_o;
  assign pop      = wb_req && !wbs_we_i && (offset == OFF_DATA) && !empty;
  assign ctrl_wr  = wb_req && wbs_we_i && (offset == OFF_CTRL) && wbs_sel_i[0];
  assign flush    = ctrl_wr && wbs_dat_i[0];
  assign tick_clr = ctrl_wr && wbs_dat_i[1];

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:2], wbs_adr_i[1:0]};

  // ---------------- event FIFO ----------------
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push_req && !flush && (!full || pop);
  assign ovf_evt = push_req && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {tick_q, 16'(idx_q)};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
  end

  // A tick clear wins over an end-of-scan increment on the same edge.
  always_ff @(posedge clk) begin
    if (rst || tick_clr) tick_q <= '0;
    else if (scan_done)  tick_q <= tick_q + 16'd1;
  end

  // ---------------- read mux and response ----------------
  assign status_word = {20'd0, scan_busy, ovf_q, full, empty, 8'(count_q)};

  always_comb begin
    rd_mux = 32'd0;
    case (offset)
      OFF_STATUS: rd_mux = status_word;
      OFF_DATA:   rd_mux = empty ? 32'hFFFF_FFFF : mem[rd_ptr_q];
      OFF_CTRL:   rd_mux = 32'd0;
      OFF_TICK:   rd_mux = {16'd0, tick_q};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= (wb_req && !wbs_we_i) ? rd_mux : 32'd0;
    end
  end

`ifdef SPIKE_OUT_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= !empty || ovf_q;
  end
`endif

endmodule
